// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 definitions: default bus widths, burst/size encodings and the
// default-width burst command record used by the burst beat generator.
package axi4_globals_pkg;

    parameter int ADDRESS_WIDTH = 32;
    parameter int DATA_WIDTH    = 32;
    parameter int ID_WIDTH      = 16;
    localparam int STRB_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } awburst_e;

    typedef enum logic [2:0] {
        AXI_SIZE_1B   = 3'd0,
        AXI_SIZE_2B   = 3'd1,
        AXI_SIZE_4B   = 3'd2,
        AXI_SIZE_8B   = 3'd3,
        AXI_SIZE_16B  = 3'd4,
        AXI_SIZE_32B  = 3'd5,
        AXI_SIZE_64B  = 3'd6,
        AXI_SIZE_128B = 3'd7
    } awsize_e;

    // Default-width burst command; parametrised users build the same layout
    // with their own widths.
    typedef struct packed {
        logic [ID_WIDTH-1:0]      id;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [7:0]               len;
        awsize_e                  size;
        awburst_e                 burst;
    } axi4_burst_cmd_s;

endpackage

// File: rtl/axi4_cmd_fifo.sv
// Synchronous command FIFO for burst commands. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module axi4_cmd_fifo
    import axi4_globals_pkg::*;
#(
    parameter type cmd_t = axi4_burst_cmd_s,
    parameter int  DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage write.
    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, so clearing the data would be wasted logic.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst beat generator: buffers burst commands and expands each into
// per-beat address, strobe, index and last flag for FIXED/INCR/WRAP bursts.
// Optional build macro AXI4_4KB_BOUNDARY_CHECK_EN flags INCR bursts that
// cross a 4KB page as erroneous.
module axi4_burst_addr_gen #(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = axi4_globals_pkg::DATA_WIDTH,
    parameter int ID_WIDTH      = axi4_globals_pkg::ID_WIDTH,
    parameter int CMD_DEPTH     = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ID_WIDTH-1:0]        cmd_id,
    input  logic [ADDRESS_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                 cmd_len,
    input  logic [2:0]                 cmd_size,
    input  logic [1:0]                 cmd_burst,
    output logic                       beat_valid,
    input  logic                       beat_ready,
    output logic [ID_WIDTH-1:0]        beat_id,
    output logic [ADDRESS_WIDTH-1:0]   beat_addr,
    output logic [DATA_WIDTH/8-1:0]    beat_strb,
    output logic [7:0]                 beat_index,
    output logic                       beat_last,
    output logic                       beat_err,
    output logic                       busy
);
    import axi4_globals_pkg::*;

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(CMD_DEPTH) + 1;

    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [BEAT_BYTES-1:0]    strb_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        addr_t               addr;
        logic [7:0]          len;
        awsize_e             size;
        awburst_e            burst;
    } cmd_t;

    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

    // Any condition that makes the whole burst answer with SLVERR.
    function automatic logic cmd_is_bad(input cmd_t c);
        int   b;
        logic bad;
        b   = 1 << c.size;
        bad = 1'b0;
        if (c.burst == AXI_BURST_RSVD) bad = 1'b1;
        if (b > BEAT_BYTES)            bad = 1'b1;
        if (c.burst == AXI_BURST_WRAP) begin
            if (!(c.len inside {8'd1, 8'd3, 8'd7, 8'd15}))  bad = 1'b1;
            if ((c.addr & addr_t'(b - 1)) != '0)            bad = 1'b1;
        end
        if (c.burst == AXI_BURST_FIXED && c.len > 8'd15) bad = 1'b1;
`ifdef AXI4_4KB_BOUNDARY_CHECK_EN
        if (c.burst == AXI_BURST_INCR) begin : page_chk
            addr_t last_byte;
            last_byte = (c.addr & ~addr_t'(b - 1))
                      + addr_t'((32'(c.len) + 32'd1) * 32'(b)) - addr_t'(1);
            if ((last_byte >> 12) != (c.addr >> 12)) bad = 1'b1;
        end
`endif
        return bad;
    endfunction

    // Lanes from the beat's own byte offset up to the end of its aligned beat.
    function automatic strb_t lane_mask(input addr_t a, input awsize_e size);
        int    b, lo, hi;
        strb_t m;
        b  = 1 << size;
        lo = int'(a & addr_t'(BEAT_BYTES - 1));
        hi = (lo & ~(b - 1)) + b - 1;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            m[k] = (k >= lo) && (k <= hi);
        end
        return m;
    endfunction

    // Address of the beat following cur.
    function automatic addr_t next_addr(input addr_t cur, input awsize_e size,
                                        input awburst_e burst, input addr_t lower,
                                        input addr_t wrap_bytes);
        addr_t b, nxt;
        b = addr_t'(1) << size;
        case (burst)
            AXI_BURST_INCR: nxt = (cur & ~(b - addr_t'(1))) + b;
            AXI_BURST_WRAP: begin
                nxt = cur + b;
                if (nxt == lower + wrap_bytes) nxt = lower;
            end
            default:        nxt = cur;
        endcase
        return nxt;
    endfunction

    state_e           state;
    cmd_t             push_cmd, head;
    logic             fifo_full, fifo_empty, push, pop, beat_fire;
    logic [CNT_W-1:0] fifo_count, count_next;
    logic [7:0]       act_len;
    awsize_e          act_size;
    awburst_e         act_burst;
    addr_t            act_lower, act_wrap_bytes;
    logic             head_bad;
    strb_t            head_strb, adv_strb;
    addr_t            head_wrap_bytes, head_lower, adv_addr;

    assign push_cmd   = '{id: cmd_id, addr: cmd_addr, len: cmd_len,
                          size: awsize_e'(cmd_size), burst: awburst_e'(cmd_burst)};
    assign push       = cmd_valid && cmd_ready;
    assign beat_fire  = beat_valid && beat_ready;
    assign pop        = !fifo_empty && ((state == ST_IDLE) || (beat_fire && beat_last));
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    axi4_cmd_fifo #(
        .cmd_t (cmd_t),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Decode the FIFO head for loading and compute the next beat of the active burst.
    // NOTE: every variable here is assigned on every pass, so no latch is inferred.
    always_comb begin
        head_bad        = cmd_is_bad(head);
        head_wrap_bytes = addr_t'((32'(head.len) + 32'd1) << head.size);
        head_lower      = head.addr & ~(head_wrap_bytes - addr_t'(1));
        head_strb       = head_bad ? '0 : lane_mask(head.addr, head.size);
        adv_addr        = next_addr(beat_addr, act_size, act_burst, act_lower, act_wrap_bytes);
        adv_strb        = lane_mask(adv_addr, act_size);
    end

    // Burst FSM with registered beat outputs; cmd_ready is registered from
    // the next occupancy so it stays low during reset and has no pass-through.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            beat_valid     <= 1'b0;
            beat_id        <= '0;
            beat_addr      <= '0;
            beat_strb      <= '0;
            beat_index     <= '0;
            beat_last      <= 1'b0;
            beat_err       <= 1'b0;
            act_len        <= '0;
            act_size       <= AXI_SIZE_1B;
            act_burst      <= AXI_BURST_FIXED;
            act_lower      <= '0;
            act_wrap_bytes <= '0;
        end else begin
            cmd_ready <= (count_next != CNT_W'(CMD_DEPTH));
            busy      <= (fifo_count != '0) || (state != ST_IDLE);
            if (pop) begin
                state          <= ST_BURST;
                beat_valid     <= 1'b1;
                beat_id        <= head.id;
                beat_addr      <= head.addr;
                beat_strb      <= head_strb;
                beat_index     <= 8'd0;
                beat_last      <= (head.len == 8'd0);
                beat_err       <= head_bad;
                act_len        <= head.len;
                act_size       <= head.size;
                act_burst      <= head.burst;
                act_lower      <= head_lower;
                act_wrap_bytes <= head_wrap_bytes;
            end else if (beat_fire) begin
                if (beat_last) begin
                    state      <= ST_IDLE;
                    beat_valid <= 1'b0;
                end else begin
                    beat_index <= beat_index + 8'd1;
                    beat_last  <= ((beat_index + 8'd1) == act_len);
                    // Erroneous bursts keep the command address and empty strobe.
                    if (!beat_err) begin
                        beat_addr <= adv_addr;
                        beat_strb <= adv_strb;
                    end
                end
            end
        end
    end

endmodule
